spi_slave_core: RTL

SPI_SLAVE_CORE -- requirements
Module: spi_slave_core

---
 rtl/spi_slave_core_pkg.sv | 13 +
 rtl/spi_sync.sv | 30 +++
 rtl/spi_slave_core.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_core_pkg.sv
// Shared types and default sizing for the SPI slave core.
package spi_slave_core_pkg;

  // Transfer state: IDLE while slave select is high, ACTIVE while a frame runs.
  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam int DEFAULT_DATA_WIDTH  = 8;
  localparam int DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with a selectable idle value on reset.
module spi_sync
  import spi_slave_core_pkg::*;
#(
  parameter int STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic rstVal_i,
  input  logic async_i,
  output logic sync_o
);

  logic [STAGES-1:0] chain_q;

  // Walk the pin through the flop chain; reset parks every stage at the pin's idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= {STAGES{rstVal_i}};
    end else begin
      chain_q[0] <= async_i;
      for (int i = 1; i < STAGES; i++) begin
        chain_q[i] <= chain_q[i-1];
      end
    end
  end

  assign sync_o = chain_q[STAGES-1];

endmodule

// File: rtl/spi_slave_core.sv
// SPI slave: oversamples SCK/SS_n/MOSI in the clk domain, supports all four CPOL/CPHA modes,
// receives MSB-first words and transmits from a one-word buffer with ready/valid handshake.
module spi_slave_core
  import spi_slave_core_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  CPOL,
  input  logic                  CPHA,
  input  logic                  SCK_in,
  input  logic                  SS_n,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic                  MISO_en,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun,
  output logic                  busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic sckSync;
  logic ssnSync;
  logic mosiSync;

  spi_sync #(.STAGES(SYNC_STAGES)) uSyncSck (
    .clk      (clk),
    .rst      (rst),
    .rstVal_i (CPOL),
    .async_i  (SCK_in),
    .sync_o   (sckSync)
  );

  spi_sync #(.STAGES(SYNC_STAGES)) uSyncSsn (
    .clk      (clk),
    .rst      (rst),
    .rstVal_i (1'b1),
    .async_i  (SS_n),
    .sync_o   (ssnSync)
  );

  spi_sync #(.STAGES(SYNC_STAGES)) uSyncMosi (
    .clk      (clk),
    .rst      (rst),
    .rstVal_i (1'b0),
    .async_i  (MOSI),
    .sync_o   (mosiSync)
  );

  state_t                state_q;
  logic                  cpol_q;
  logic                  cpha_q;
  logic                  sckPrev_q;
  logic [CNT_W-1:0]      bitCnt_q;
  logic [DATA_WIDTH-1:0] rxShift_q;
  logic [DATA_WIDTH-1:0] rxData_q;
  logic [DATA_WIDTH-1:0] txShift_q;
  logic                  misoBit_q;
  logic                  wordDone_q;
  logic                  rxValid_q;
  logic                  txUnderrun_q;
  logic [DATA_WIDTH-1:0] txBuf_q;
  logic [DATA_WIDTH-1:0] txBuf_d;
  logic                  txFull_q;
  logic                  txFull_d;

  logic                  leadEdge;
  logic                  trailEdge;
  logic                  sampleEdge;
  logic                  shiftEdge;
  logic                  startWord;
  logic                  boundaryLoad;
  logic                  loadWord;
  logic                  accept;
  logic [DATA_WIDTH-1:0] loadValue;
  logic [DATA_WIDTH-1:0] rxNext;

  // Edge roles from the mode latched at frame start; the next word is fetched lazily at the
  // first shift edge after a completed word, so a final word never triggers a needless fetch.
  always_comb begin
    leadEdge     = (state_q == ACTIVE) && (sckPrev_q == cpol_q) && (sckSync != cpol_q);
    trailEdge    = (state_q == ACTIVE) && (sckPrev_q != cpol_q) && (sckSync == cpol_q);
    sampleEdge   = cpha_q ? trailEdge : leadEdge;
    shiftEdge    = cpha_q ? leadEdge : trailEdge;
    startWord    = (state_q == IDLE) && !ssnSync;
    boundaryLoad = (state_q == ACTIVE) && !ssnSync && shiftEdge && wordDone_q;
    loadWord     = startWord || boundaryLoad;
    loadValue    = txFull_q ? txBuf_q : '0;
    accept       = tx_valid && !txFull_q;
    rxNext       = {rxShift_q[DATA_WIDTH-2:0], mosiSync};
  end

  // TX buffer next state: a load empties it, an accept in the same cycle refills it.
  always_comb begin
    txBuf_d  = txBuf_q;
    txFull_d = txFull_q;
    if (loadWord) begin
      txFull_d = 1'b0;
    end
    if (accept) begin
      txBuf_d  = tx_data;
      txFull_d = 1'b1;
    end
  end

  // TX buffer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      txBuf_q  <= '0;
      txFull_q <= 1'b0;
    end else begin
      txBuf_q  <= txBuf_d;
      txFull_q <= txFull_d;
    end
  end

  // Frame FSM: mode capture in IDLE, bit sampling/shifting in ACTIVE, abort on SS_n rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cpol_q       <= CPOL;
      cpha_q       <= CPHA;
      sckPrev_q    <= CPOL;
      bitCnt_q     <= '0;
      rxShift_q    <= '0;
      rxData_q     <= '0;
      txShift_q    <= '0;
      misoBit_q    <= 1'b0;
      wordDone_q   <= 1'b0;
      rxValid_q    <= 1'b0;
      txUnderrun_q <= 1'b0;
    end else begin
      sckPrev_q    <= sckSync;
      rxValid_q    <= 1'b0;
      txUnderrun_q <= loadWord && !txFull_q;
      case (state_q)
        IDLE: begin
          cpol_q <= CPOL;
          cpha_q <= CPHA;
          if (!ssnSync) begin
            state_q   <= ACTIVE;
            txShift_q <= loadValue;
            misoBit_q <= CPHA ? 1'b0 : loadValue[DATA_WIDTH-1];
          end
        end
        ACTIVE: begin
          if (ssnSync) begin
            state_q    <= IDLE;
            bitCnt_q   <= '0;
            rxShift_q  <= '0;
            txShift_q  <= '0;
            misoBit_q  <= 1'b0;
            wordDone_q <= 1'b0;
          end else begin
            if (sampleEdge) begin
              rxShift_q <= rxNext;
              if (bitCnt_q == LAST_BIT) begin
                bitCnt_q   <= '0;
                rxData_q   <= rxNext;
                rxValid_q  <= 1'b1;
                wordDone_q <= 1'b1;
              end else begin
                bitCnt_q <= bitCnt_q + CNT_W'(1);
              end
            end
            if (shiftEdge) begin
              if (wordDone_q) begin
                wordDone_q <= 1'b0;
                misoBit_q  <= loadValue[DATA_WIDTH-1];
                txShift_q  <= cpha_q ? {loadValue[DATA_WIDTH-2:0], 1'b0} : loadValue;
              end else begin
                misoBit_q  <= cpha_q ? txShift_q[DATA_WIDTH-1] : txShift_q[DATA_WIDTH-2];
                txShift_q  <= {txShift_q[DATA_WIDTH-2:0], 1'b0};
              end
            end
          end
        end
      endcase
    end
  end

  assign busy        = (state_q == ACTIVE);
  assign MISO_en     = (state_q == ACTIVE);
  assign MISO        = misoBit_q && (state_q == ACTIVE);
  assign tx_ready    = !txFull_q;
  assign rx_data     = rxData_q;
  assign rx_valid    = rxValid_q;
  assign tx_underrun = txUnderrun_q;

endmodule
